vram_arbiter: RTL and testbench
===============================

# vram_arbiter

Single-port video RAM arbiter between the HDMI video fetch and the Z80 CPU. The video fetch has absolute priority and fixed 2-cycle read latency, so pixel timing is never disturbed. CPU accesses use a request/ack handshake, are slotted into free RAM cycles, and raise a WAIT level while held off. The block sits between the CPU bus decode, the hdmi_video fetch port and the 8 KB screen RAM.

## Interface
- AW, 13: RAM address width.
- DW, 8: RAM data width.
- clk_pix  in  1  pixel clock (25.2 MHz); the only clock.
- nreset  in  1  reset; asynchronous assert, active-low.
- vid_req  in  1  video read request for this cycle.
- vid_addr  in  AW  video read address; valid with vid_req.
- vid_data  out  DW  video read data.
- vid_valid  out  1  one-cycle strobe; vid_data valid.
- cpu_req  in  1  CPU request level; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; captured with the request.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_rdata  out  DW  CPU read data; valid with cpu_ack on reads.
- cpu_ack  out  1  one-cycle completion strobe.
- cpu_wait  out  1  request accepted but not yet acked (drives Z80 WAIT).
- ram_addr  out  AW  RAM address (combinational mux).
- ram_wdata  out  DW  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_rdata  in  DW  synchronous RAM read data, valid the cycle after the address.

## Operation
- CPU FSM states: C_IDLE, C_PEND, C_RD, C_ACK.
  - C_IDLE: if cpu_req, capture cpu_we/addr/wdata and go to C_PEND.
  - C_PEND: cpu_wait=1. If vid_req=0 this cycle, issue the captured access on the RAM port. A read goes to C_RD. A write drives ram_we=1 and goes to C_ACK.
  - C_RD: capture ram_rdata into cpu_rdata, then go to C_ACK.
  - C_ACK: cpu_ack=1 for one cycle, then go to C_IDLE. If cpu_req is still high in C_IDLE it is treated as a new request.
- Video path: whenever vid_req=1, ram_addr=vid_addr and ram_we=0, unconditionally. An owner tag is pipelined 2 deep; a video tag loads ram_rdata into vid_data and pulses vid_valid.
- Simultaneous vid_req and C_PEND: video wins. The CPU stays in C_PEND and cpu_wait stays high.
- Video usage guarantee: at most 2 of every 16 cycles, so CPU wait is bounded at 2 cycles.
- Idle RAM port: ram_addr holds the last value, ram_we=0.

## Timing
- Reset values: vid_data=0, vid_valid=0, cpu_rdata=0, cpu_ack=0, cpu_wait=0, ram_we=0, FSM=C_IDLE, tag pipeline empty, buffer empty.
- Video latency: vid_req in cycle t gives vid_valid in cycle t+2, back-to-back capable.
- CPU read: issued in cycle t, cpu_ack and cpu_rdata in cycle t+2.
- CPU write: issued in cycle t, cpu_ack in cycle t+1.
- Uncontended request: cpu_req seen in cycle t is issued in t+1 (C_PEND).
- Reset mid-operation: in-flight accesses are dropped with no ack and no vid_valid. A RAM write already strobed is not undone.

## Configuration
- VRAM_ARB_WRITE_BUFFER_EN defined: adds a one-entry posted write buffer.
  - A write in C_IDLE with the buffer empty is acked next cycle and the buffer is filled.
  - The buffer drains in the first cycle with vid_req=0.
  - A write with the buffer full holds in C_PEND (cpu_wait=1) until the buffer drains.
  - A read while the buffer is full waits until it drains, so read-after-write order is preserved.
- Undefined: writes follow the C_PEND path. No buffer logic is synthesised.

## Structure
- vram_arb_pkg holds the AW/DW defaults, the CPU FSM state enum and the owner-tag enum (T_NONE, T_VID, T_CPU).
- Optional sub-module vram_wbuf (buffer register, full flag, drain handshake) is instantiated only under VRAM_ARB_WRITE_BUFFER_EN.

## Test plan
- Video only: vid_req at cycles 10 and 12 with addresses 0x0005 and 0x1805 -> vid_valid at 12 and 14 with the RAM contents; cpu_wait=0 throughout.
- Uncontended CPU read of 0x0100 (RAM=0xA5) -> ram_addr=0x0100 one cycle after request; cpu_ack with cpu_rdata=0xA5 three cycles after request.
- Contention: CPU write 0x0200<=0x3C requested while vid_req is high for 2 cycles -> cpu_wait high 2 extra cycles, ram_we only after vid_req drops, vid_valid timing unchanged.
- nreset pulsed during C_RD -> no cpu_ack, all outputs 0, and the next request completes normally.
- With VRAM_ARB_WRITE_BUFFER_EN: write 0x0300<=0x11 during video burst -> ack one cycle after request; an immediate read of 0x0300 returns 0x11.
- Handshake repeat: cpu_req held high across cpu_ack -> second access starts in the C_IDLE cycle and exactly two acks are produced.

Source files
------------

// File: rtl/vram_arb_pkg.sv
// vram_arb_pkg: shared widths and enums for the VRAM arbiter.
//   AW / DW  : RAM address / data width (8 KB x 8 screen RAM)
//   cpu_state_e : CPU access FSM states
//   owner_e     : tag travelling alongside a RAM read to route its data
package vram_arb_pkg;

   localparam int AW = 13;
   localparam int DW = 8;

   typedef enum logic [1:0] {
      C_IDLE = 2'd0,
      C_PEND = 2'd1,
      C_RD   = 2'd2,
      C_ACK  = 2'd3
   } cpu_state_e;

   typedef enum logic [1:0] {
      T_NONE = 2'd0,
      T_VID  = 2'd1,
      T_CPU  = 2'd2
   } owner_e;

endpackage

// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: video fetch, CPU bus and RAM port signals of the arbiter.
//   slave  : arbiter view (takes video/CPU requests, drives the RAM port)
//   master : environment view (video fetch, CPU decode and RAM)
interface vram_arbiter_if;
   import vram_arb_pkg::*;

   logic          vid_req;
   logic [AW-1:0] vid_addr;
   logic [DW-1:0] vid_data;
   logic          vid_valid;

   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_ack;
   logic          cpu_wait;

   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic          ram_we;
   logic [DW-1:0] ram_rdata;

   modport slave (
      input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
      output vid_data, vid_valid, cpu_rdata, cpu_ack, cpu_wait,
             ram_addr, ram_wdata, ram_we
   );

   modport master (
      output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
      input  vid_data, vid_valid, cpu_rdata, cpu_ack, cpu_wait,
             ram_addr, ram_wdata, ram_we
   );

endinterface

// File: rtl/vram_wbuf.sv
// vram_wbuf: one-entry posted write buffer for the CPU side of vram_arbiter.
// Only exists when VRAM_ARB_WRITE_BUFFER_EN is defined.
//   clk_pix, nreset : clock, async active-low reset
//   fill            : load addr_in/data_in, buffer becomes full
//   port_idle       : RAM port not claimed by video this cycle
//   full            : buffer holds an undrained write
//   drain           : buffered write is on the RAM port this cycle
//   addr, data      : buffered write
`ifdef VRAM_ARB_WRITE_BUFFER_EN
module vram_wbuf
   import vram_arb_pkg::*;
(
   input  logic          clk_pix,
   input  logic          nreset,
   input  logic          fill,
   input  logic          port_idle,
   input  logic [AW-1:0] addr_in,
   input  logic [DW-1:0] data_in,
   output logic          full,
   output logic          drain,
   output logic [AW-1:0] addr,
   output logic [DW-1:0] data
);

   logic          full_q, full_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] data_q, data_d;

   // fill is only raised while empty, so it never coincides with drain
   always_comb begin
      drain  = full_q && port_idle;
      full_d = full_q;
      addr_d = addr_q;
      data_d = data_q;
      if (fill) begin
         full_d = 1'b1;
         addr_d = addr_in;
         data_d = data_in;
      end else if (drain) begin
         full_d = 1'b0;
      end
   end

   always_ff @(posedge clk_pix or negedge nreset) begin
      if (!nreset) begin
         full_q <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
      end else begin
         full_q <= full_d;
         addr_q <= addr_d;
         data_q <= data_d;
      end
   end

   assign full = full_q;
   assign addr = addr_q;
   assign data = data_q;

endmodule
`endif

// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port screen RAM shared by the HDMI video fetch
// (absolute priority, fixed 2-cycle read latency) and the Z80 CPU
// (req/ack handshake, WAIT while held off).
//   clk_pix, nreset : pixel clock, async active-low reset
//   bus (slave)     : vid_* fetch port, cpu_* bus port, ram_* RAM port
// Optional: VRAM_ARB_WRITE_BUFFER_EN adds a one-entry posted write buffer.
//
// state  | meaning
// C_IDLE | no CPU access; a request is captured here
// C_PEND | captured access waiting for a free RAM cycle (cpu_wait=1)
// C_RD   | read issued last cycle; ram_rdata captured (cpu_wait=1)
// C_ACK  | cpu_ack pulse
module vram_arbiter
   import vram_arb_pkg::*;
(
   input  logic          clk_pix,
   input  logic          nreset,
   vram_arbiter_if.slave bus
);

   cpu_state_e    state_q, state_d;
   logic          cpu_we_q, cpu_we_d;
   logic [AW-1:0] cpu_addr_q, cpu_addr_d;
   logic [DW-1:0] cpu_wdata_q, cpu_wdata_d;
   logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DW-1:0] vid_data_q, vid_data_d;
   logic [AW-1:0] last_addr_q, last_addr_d;
   owner_e        tag0_q, tag0_d;
   owner_e        tag1_q, tag1_d;

   logic          cpu_take;
   logic          port_free;
   logic          cpu_issue;
   logic          wbuf_fill;
   logic          wbuf_drain;
   logic [AW-1:0] wbuf_addr;
   logic [DW-1:0] wbuf_data;
   owner_e        owner;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic          ram_we;

   assign cpu_take = (state_q == C_IDLE) && bus.cpu_req;

`ifdef VRAM_ARB_WRITE_BUFFER_EN
   logic wbuf_full;

   // A pending access also waits for the buffer so reads see posted writes
   assign wbuf_fill = cpu_take && bus.cpu_we && !wbuf_full;
   assign port_free = !bus.vid_req && !wbuf_full;

   vram_wbuf u_wbuf (
      .clk_pix   (clk_pix),
      .nreset    (nreset),
      .fill      (wbuf_fill),
      .port_idle (!bus.vid_req),
      .addr_in   (bus.cpu_addr),
      .data_in   (bus.cpu_wdata),
      .full      (wbuf_full),
      .drain     (wbuf_drain),
      .addr      (wbuf_addr),
      .data      (wbuf_data)
   );
`else
   assign wbuf_fill  = 1'b0;
   assign wbuf_drain = 1'b0;
   assign wbuf_addr  = '0;
   assign wbuf_data  = '0;
   assign port_free  = !bus.vid_req;
`endif

   always_ff @(posedge clk_pix or negedge nreset) begin
      if (!nreset) begin
         state_q     <= C_IDLE;
         cpu_we_q    <= 1'b0;
         cpu_addr_q  <= '0;
         cpu_wdata_q <= '0;
         cpu_rdata_q <= '0;
         vid_data_q  <= '0;
         last_addr_q <= '0;
         tag0_q      <= T_NONE;
         tag1_q      <= T_NONE;
      end else begin
         state_q     <= state_d;
         cpu_we_q    <= cpu_we_d;
         cpu_addr_q  <= cpu_addr_d;
         cpu_wdata_q <= cpu_wdata_d;
         cpu_rdata_q <= cpu_rdata_d;
         vid_data_q  <= vid_data_d;
         last_addr_q <= last_addr_d;
         tag0_q      <= tag0_d;
         tag1_q      <= tag1_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         C_IDLE:  if (cpu_take) state_d = wbuf_fill ? C_ACK : C_PEND;
         C_PEND:  if (port_free) state_d = cpu_we_q ? C_ACK : C_RD;
         C_RD:    state_d = C_ACK;
         C_ACK:   state_d = C_IDLE;
         default: state_d = C_IDLE;
      endcase
   end

   // RAM port: video always wins; otherwise buffer drain, then CPU, else hold
   always_comb begin
      cpu_issue = (state_q == C_PEND) && port_free;
      ram_addr  = last_addr_q;
      ram_wdata = cpu_wdata_q;
      ram_we    = 1'b0;
      owner     = T_NONE;
      if (bus.vid_req) begin
         ram_addr = bus.vid_addr;
         owner    = T_VID;
      end else if (wbuf_drain) begin
         ram_addr  = wbuf_addr;
         ram_wdata = wbuf_data;
         ram_we    = 1'b1;
      end else if (cpu_issue) begin
         ram_addr = cpu_addr_q;
         ram_we   = cpu_we_q;
         owner    = cpu_we_q ? T_NONE : T_CPU;
      end
   end

   always_comb begin
      cpu_we_d    = cpu_we_q;
      cpu_addr_d  = cpu_addr_q;
      cpu_wdata_d = cpu_wdata_q;
      if (cpu_take) begin
         cpu_we_d    = bus.cpu_we;
         cpu_addr_d  = bus.cpu_addr;
         cpu_wdata_d = bus.cpu_wdata;
      end
      // tag0 marks the cycle ram_rdata belongs to the access issued before
      cpu_rdata_d = (tag0_q == T_CPU) ? bus.ram_rdata : cpu_rdata_q;
      vid_data_d  = (tag0_q == T_VID) ? bus.ram_rdata : vid_data_q;
      tag0_d      = owner;
      tag1_d      = tag0_q;
      last_addr_d = ram_addr;
   end

   assign bus.ram_addr  = ram_addr;
   assign bus.ram_wdata = ram_wdata;
   assign bus.ram_we    = ram_we;
   assign bus.vid_data  = vid_data_q;
   assign bus.vid_valid = (tag1_q == T_VID);
   assign bus.cpu_rdata = cpu_rdata_q;
   assign bus.cpu_ack   = (state_q == C_ACK);
   assign bus.cpu_wait  = (state_q == C_PEND) || (state_q == C_RD);

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed stimulus with a scoreboard for vram_arbiter.
// Expected vid_valid / cpu_ack events are queued with data and cycle; a
// negedge monitor pops and compares them as the DUT produces strobes.
module tb_vram_arbiter;
   import vram_arb_pkg::*;

   typedef struct {
      logic [7:0] data;
      int         cyc;
   } vexp_t;

   typedef struct {
      bit         rd;
      logic [7:0] data;
      int         cyc;
   } cexp_t;

   logic clk_pix = 1'b0;
   logic nreset  = 1'b0;
   int   cyc     = 0;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_acks   = 0;

   vexp_t vq[$];
   cexp_t cq[$];

   logic [7:0]    mem [0:8191];
   logic          pl_we   = 1'b0;
   logic [12:0]   pl_addr = '0;
   logic [7:0]    pl_data = '0;

   vram_arbiter_if vif();

   vram_arbiter dut (
      .clk_pix (clk_pix),
      .nreset  (nreset),
      .bus     (vif)
   );

   always #20 clk_pix = ~clk_pix;

   always @(posedge clk_pix) cyc <= cyc + 1;

   // synchronous RAM: read data valid the cycle after the address
   always @(posedge clk_pix) begin
      if (pl_we) mem[pl_addr] <= pl_data;
      else if (vif.ram_we) mem[vif.ram_addr] <= vif.ram_wdata;
      vif.ram_rdata <= mem[vif.ram_addr];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic step();
      @(posedge clk_pix);
      #1;
   endtask

   task automatic exp_vid(input logic [7:0] d);
      vexp_t e;
      e.data = d;
      e.cyc  = cyc + 2;
      vq.push_back(e);
   endtask

   task automatic exp_cpu(input bit rd, input logic [7:0] d, input int c);
      cexp_t e;
      e.rd   = rd;
      e.data = d;
      e.cyc  = c;
      cq.push_back(e);
   endtask

   // monitor / scoreboard
   always @(negedge clk_pix) begin
      vexp_t ve;
      cexp_t ce;
      if (vif.vid_valid) begin
         if (vq.size() == 0) check("vid_unexpected", vif.vid_valid, 1'b0);
         else begin
            ve = vq.pop_front();
            check("vid_cycle", cyc, ve.cyc);
            check("vid_data", vif.vid_data, ve.data);
         end
      end
      if (vif.cpu_ack) begin
         n_acks++;
         if (cq.size() == 0) check("ack_unexpected", vif.cpu_ack, 1'b0);
         else begin
            ce = cq.pop_front();
            check("ack_cycle", cyc, ce.cyc);
            if (ce.rd) check("cpu_rdata", vif.cpu_rdata, ce.data);
         end
      end
   end

   // uncontended read: PEND t+1 (addr on port), RD t+2, ACK t+3
   task automatic cpu_read(input logic [12:0] a, input logic [7:0] d);
      int t0;
      step();
      t0 = cyc;
      vif.cpu_req  = 1'b1;
      vif.cpu_we   = 1'b0;
      vif.cpu_addr = a;
      exp_cpu(1'b1, d, t0 + 3);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) step();
         if (i == 4) vif.cpu_req = 1'b0;
         @(negedge clk_pix);
         if (i == 1) check("rd_ram_addr", vif.ram_addr, a);
         check("rd_wait", vif.cpu_wait, (i == 1 || i == 2));
      end
   endtask

   initial begin
      #(40 * 20000);
      $display("FAIL watchdog: got timeout, required $finish");
      $fatal(1);
   end

   initial begin
      int t0;
      int acks0;
      vif.vid_req   = 1'b0;
      vif.vid_addr  = '0;
      vif.cpu_req   = 1'b0;
      vif.cpu_we    = 1'b0;
      vif.cpu_addr  = '0;
      vif.cpu_wdata = '0;

      // preload RAM while held in reset
      step(); pl_we = 1'b1; pl_addr = 13'h0005; pl_data = 8'h5A;
      step(); pl_addr = 13'h1805; pl_data = 8'hC3;
      step(); pl_addr = 13'h0100; pl_data = 8'hA5;
      step(); pl_addr = 13'h0200; pl_data = 8'h00;
      step(); pl_we = 1'b0;
      @(negedge clk_pix);
      check("rst_vid_valid", vif.vid_valid, 1'b0);
      check("rst_vid_data",  vif.vid_data,  8'h00);
      check("rst_cpu_rdata", vif.cpu_rdata, 8'h00);
      check("rst_cpu_ack",   vif.cpu_ack,   1'b0);
      check("rst_cpu_wait",  vif.cpu_wait,  1'b0);
      check("rst_ram_we",    vif.ram_we,    1'b0);
      step(); nreset = 1'b1;
      repeat (2) step();

      // video only, reads at rel 0 and 2
      for (int i = 0; i < 6; i++) begin
         step();
         vif.vid_req  = (i == 0 || i == 2);
         vif.vid_addr = (i == 0) ? 13'h0005 : 13'h1805;
         if (i == 0) exp_vid(8'h5A);
         if (i == 2) exp_vid(8'hC3);
         @(negedge clk_pix);
         check("vo_wait", vif.cpu_wait, 1'b0);
         check("vo_ram_we", vif.ram_we, 1'b0);
         if (i == 0 || i == 2) check("vo_ram_addr", vif.ram_addr, vif.vid_addr);
      end
      vif.vid_req = 1'b0;
      step();

      cpu_read(13'h0100, 8'hA5);
      step();

      // write 0x0200 <= 0x3C, video holds the port at rel 1 and 2
      step();
      t0 = cyc;
      vif.cpu_req   = 1'b1;
      vif.cpu_we    = 1'b1;
      vif.cpu_addr  = 13'h0200;
      vif.cpu_wdata = 8'h3C;
`ifdef VRAM_ARB_WRITE_BUFFER_EN
      exp_cpu(1'b0, 8'h00, t0 + 1);
`else
      exp_cpu(1'b0, 8'h00, t0 + 4);
`endif
      for (int i = 0; i < 6; i++) begin
         if (i > 0) step();
         vif.vid_req  = (i == 1 || i == 2);
         vif.vid_addr = (i == 1) ? 13'h0005 : 13'h1805;
         if (i == 1) exp_vid(8'h5A);
         if (i == 2) exp_vid(8'hC3);
`ifdef VRAM_ARB_WRITE_BUFFER_EN
         if (i == 2) vif.cpu_req = 1'b0;
`else
         if (i == 5) vif.cpu_req = 1'b0;
`endif
         @(negedge clk_pix);
         check("ct_ram_we", vif.ram_we, (i == 3));
`ifdef VRAM_ARB_WRITE_BUFFER_EN
         check("ct_wait", vif.cpu_wait, 1'b0);
`else
         check("ct_wait", vif.cpu_wait, (i >= 1 && i <= 3));
`endif
         if (i == 3) begin
            check("ct_ram_addr", vif.ram_addr, 13'h0200);
            check("ct_ram_wdata", vif.ram_wdata, 8'h3C);
         end
      end
      step();
      cpu_read(13'h0200, 8'h3C);
      step();

      // reset while the CPU read sits in C_RD, with a video read in flight
      step();
      t0 = cyc;
      vif.cpu_req  = 1'b1;
      vif.cpu_we   = 1'b0;
      vif.cpu_addr = 13'h0100;
      vif.vid_req  = 1'b1;
      vif.vid_addr = 13'h0005;
      step(); vif.vid_req = 1'b0;
      step();
      nreset = 1'b0;
      vif.cpu_req = 1'b0;
      @(negedge clk_pix);
      check("mr_vid_valid", vif.vid_valid, 1'b0);
      check("mr_vid_data",  vif.vid_data,  8'h00);
      check("mr_cpu_rdata", vif.cpu_rdata, 8'h00);
      check("mr_cpu_ack",   vif.cpu_ack,   1'b0);
      check("mr_cpu_wait",  vif.cpu_wait,  1'b0);
      check("mr_ram_we",    vif.ram_we,    1'b0);
      check("mr_ram_addr",  vif.ram_addr,  13'h0000);
      step();
      @(negedge clk_pix);
      check("mr_no_ack", vif.cpu_ack, 1'b0);
      step(); nreset = 1'b1;
      repeat (2) step();
      cpu_read(13'h0100, 8'hA5);
      step();

      // cpu_req held across the first ack: second read starts in C_IDLE
      step();
      t0 = cyc;
      acks0 = n_acks;
      vif.cpu_req  = 1'b1;
      vif.cpu_we   = 1'b0;
      vif.cpu_addr = 13'h0100;
      exp_cpu(1'b1, 8'hA5, t0 + 3);
      exp_cpu(1'b1, 8'hA5, t0 + 7);
      for (int i = 0; i < 10; i++) begin
         if (i > 0) step();
         if (i == 5) vif.cpu_req = 1'b0;
         @(negedge clk_pix);
         if (i == 5) check("hs_second_pend", vif.cpu_wait, 1'b1);
      end
      step();
      check("hs_two_acks", n_acks - acks0, 2);

`ifdef VRAM_ARB_WRITE_BUFFER_EN
      // posted write during a 4-cycle video burst, then read-after-write
      step();
      t0 = cyc;
      vif.cpu_req   = 1'b1;
      vif.cpu_we    = 1'b1;
      vif.cpu_addr  = 13'h0300;
      vif.cpu_wdata = 8'h11;
      exp_cpu(1'b0, 8'h00, t0 + 1);
      for (int i = 0; i < 10; i++) begin
         if (i > 0) step();
         vif.vid_req  = (i <= 3);
         vif.vid_addr = (i[0] == 1'b0) ? 13'h0005 : 13'h1805;
         if (i <= 3) exp_vid((i[0] == 1'b0) ? 8'h5A : 8'hC3);
         if (i == 2) begin
            vif.cpu_we = 1'b0;
            exp_cpu(1'b1, 8'h11, t0 + 7);
         end
         if (i == 8) vif.cpu_req = 1'b0;
         @(negedge clk_pix);
         check("wb_ram_we", vif.ram_we, (i == 4));
         check("wb_wait", vif.cpu_wait, (i >= 3 && i <= 6));
         if (i == 4) begin
            check("wb_drain_addr", vif.ram_addr, 13'h0300);
            check("wb_drain_data", vif.ram_wdata, 8'h11);
         end
      end
      step();
`endif

      repeat (4) step();
      check("vid_queue_empty", vq.size(), 0);
      check("cpu_queue_empty", cq.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
